// File: rtl/bounce_pkg.sv
// rtl/bounce_pkg.sv - shared state encoding and LFSR constants for the bounce emulator
package bounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned TOG_W    = 5;
  localparam int unsigned SEG_W    = 4;
  localparam int unsigned SETTLE_W = 8;

  function automatic logic lfsr_feedback(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// rtl/bounce_lfsr.sv - free-running 16-bit Fibonacci LFSR, one step per clock
module bounce_lfsr
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], lfsr_feedback(q)};
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - switch contact bounce emulator; BOUNCE_LFSR_EN gives random 1..4 cycle segments
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned N_BOUNCE   = 4,
  parameter int unsigned GLITCH_LEN = 2,
  parameter int unsigned SETTLE     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean_in,
  input  logic en,
  output logic noisy_out,
  output logic busy,
  output logic done
);

  localparam int unsigned TOGGLES = 2 * N_BOUNCE - 1;

  state_t              state, state_nxt;
  logic                noisy_nxt;
  logic                target, target_nxt;
  logic [SEG_W-1:0]    seg_cnt, seg_nxt;
  logic [SEG_W-1:0]    seg_len;
  logic [SEG_W-1:0]    new_len;
  logic                seg_start;
  logic [TOG_W-1:0]    tog_cnt, tog_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;

`ifdef BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;

  bounce_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign new_len = {2'b00, lfsr_q[1:0]} + 4'd1;
`else
  assign new_len = SEG_W'(GLITCH_LEN);
`endif

  // Segment length is captured at the start of each segment so it stays fixed while counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_len <= '0;
    end else if (seg_start) begin
      seg_len <= new_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      noisy_out  <= 1'b0;
      target     <= 1'b0;
      seg_cnt    <= '0;
      tog_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      noisy_out  <= noisy_nxt;
      target     <= target_nxt;
      seg_cnt    <= seg_nxt;
      tog_cnt    <= tog_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    noisy_nxt  = noisy_out;
    target_nxt = target;
    seg_nxt    = seg_cnt;
    tog_nxt    = tog_cnt;
    settle_nxt = settle_cnt;
    seg_start  = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        // Bypass and sequence start both land noisy_out on clean_in at the next edge
        noisy_nxt = clean_in;
        if (en && (clean_in != noisy_out)) begin
          target_nxt = clean_in;
          seg_nxt    = SEG_W'(1);
          tog_nxt    = TOG_W'(1);
          settle_nxt = '0;
          seg_start  = 1'b1;
          state_nxt  = (TOGGLES == 1) ? ST_SETTLE : ST_BOUNCE;
        end
      end

      ST_BOUNCE: begin
        if (seg_cnt >= seg_len) begin
          noisy_nxt = ~noisy_out;
          seg_nxt   = SEG_W'(1);
          tog_nxt   = tog_cnt + TOG_W'(1);
          seg_start = 1'b1;
          if ((tog_cnt + TOG_W'(1)) == TOG_W'(TOGGLES)) begin
            noisy_nxt  = target;
            settle_nxt = '0;
            state_nxt  = ST_SETTLE;
          end
        end else begin
          seg_nxt = seg_cnt + SEG_W'(1);
        end
      end

      ST_SETTLE: begin
        noisy_nxt = target;
        if (settle_cnt == SETTLE_W'(SETTLE)) begin
          done       = 1'b1;
          settle_nxt = '0;
          seg_nxt    = '0;
          tog_nxt    = '0;
          state_nxt  = ST_IDLE;
        end else begin
          settle_nxt = settle_cnt + SETTLE_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bounce_gen.sv
// tb/tb_bounce_gen.sv - directed self-checking bench for bounce_gen with a 3-stage debouncer probe
module tb_bounce_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic clean_in;
  logic en;
  logic noisy_out;
  logic busy;
  logic done;

  int checks = 0;
  int fails  = 0;

  logic [2:0] sr;
  logic       deb;
  logic       deb_prev;
  int         rises;
  int         rise_k;
  logic       got;
  logic       last_clean;

  always #5 clk = ~clk;

  bounce_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clean_in  (clean_in),
    .en        (en),
    .noisy_out (noisy_out),
    .busy      (busy),
    .done      (done)
  );

  // downstream shift-register debouncer: output flips only after 3 equal samples
  always @(posedge clk) begin
    if (!rst_n) begin
      sr  <= 3'b000;
      deb <= 1'b0;
    end else begin
      sr <= {sr[1:0], noisy_out};
      if (sr == 3'b111) deb <= 1'b1;
      else if (sr == 3'b000) deb <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // expected noisy_out j cycles after the triggering cycle, default parameters
  function automatic logic exp_noisy(input int j, input logic tgt);
    if (j <= 0) return ~tgt;
    if (j >= 13) return tgt;
    return ((((j - 1) / 2) % 2) == 0) ? tgt : ~tgt;
  endfunction

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    clean_in = 1'b0;
    step();
    step();
    chk("reset_noisy", noisy_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    rst_n = 1'b1;
    en    = 1'b1;
    step();
    step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_noisy", noisy_out, 1'b0);

`ifndef BOUNCE_LFSR_EN
    // rising transition with debouncer observation
    clean_in = 1'b1;
    rises    = 0;
    rise_k   = -1;
    deb_prev = deb;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("rise_noisy", noisy_out, exp_noisy(k, 1'b1));
      chk("rise_done", done, (k == 16));
      chk("rise_busy", busy, (k <= 16));
      if (deb && !deb_prev) begin
        rises++;
        rise_k = k;
      end
      deb_prev = deb;
    end
    chk("deb_rise_count", rises, 1);
    chk("deb_rise_cycle", rise_k, 17);

    // falling transition; en dropped mid-sequence must not abort
    clean_in = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("fall_noisy", noisy_out, exp_noisy(k, 1'b0));
      chk("fall_done", done, (k == 16));
      chk("fall_busy", busy, (k <= 16));
      if (k == 3) en = 1'b0;
    end
    en = 1'b1;

    // clean_in reverts at k=4; rising completes, falling starts at k=18
    clean_in = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      step();
      chk("mid_noisy", noisy_out, (k <= 17) ? exp_noisy(k, 1'b1) : exp_noisy(k - 17, 1'b0));
      chk("mid_done", done, (k == 16) || (k == 33));
      chk("mid_busy", busy, (k <= 16) || ((k >= 18) && (k <= 33)));
      if (k == 4) clean_in = 1'b0;
    end
`endif

    // reset mid-sequence, then restart on release with clean_in high
    clean_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("rstseq_done", done, 1'b0);
      chk("rstseq_busy", busy, 1'b1);
    end
    rst_n = 1'b0;
    step();
    chk("rstseq_noisy", noisy_out, 1'b0);
    chk("rstseq_busy_clr", busy, 1'b0);
    chk("rstseq_done_clr", done, 1'b0);
    rst_n = 1'b1;
    step();
    chk("restart_noisy", noisy_out, 1'b1);
    chk("restart_busy", busy, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      step();
      if (done) got = 1'b1;
    end
    chk("restart_done_seen", got, 1'b1);
    step();

    // bypass: clean_in toggled every 5 cycles
    en         = 1'b0;
    last_clean = clean_in;
    for (int i = 0; i < 30; i++) begin
      step();
      chk("bypass_noisy", noisy_out, last_clean);
      chk("bypass_busy", busy, 1'b0);
      chk("bypass_done", done, 1'b0);
      if ((i % 5) == 4) clean_in = ~clean_in;
      last_clean = clean_in;
    end

`ifdef BOUNCE_LFSR_EN
    clean_in = 1'b0;
    step();
    step();
    en = 1'b1;
    for (int tr = 0; tr < 1000; tr++) begin
      int   toggles;
      int   last_change;
      logic prev;
      clean_in    = ~clean_in;
      toggles     = 0;
      last_change = -1;
      prev        = noisy_out;
      got         = 1'b0;
      for (int c = 1; c <= 200 && !got; c++) begin
        step();
        if (noisy_out !== prev) begin
          toggles++;
          if (last_change >= 0)
            chk("lfsr_seg_len", ((c - last_change) >= 1) && ((c - last_change) <= 4), 1'b1);
          last_change = c;
          prev        = noisy_out;
        end
        if (done) got = 1'b1;
      end
      chk("lfsr_toggles", toggles, 7);
      chk("lfsr_done_seen", got, 1'b1);
      chk("lfsr_final_level", noisy_out, clean_in);
      step();
    end
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
